// File: rtl/mem_bridge.sv
// mem_bridge: single-outstanding CPU-to-bus bridge.
// The CPU holds mem_read/mem_write until a one-cycle mem_resp. Each access is
// captured once in IDLE, presented on the bus in REQ, and completed when the bus
// response arrives in WAIT. The RESP cycle is the single mem_resp cycle.
// err is sticky until rst. It is set by a read+write collision, by a stray
// bus_rsp_valid, and (optionally) by a timeout.
// Optional build macro: MEM_BRIDGE_TIMEOUT_EN adds an 8-bit WAIT timeout that
// forces a response after TIMEOUT_CYCLES WAIT cycles.
module mem_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] mem_address,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_byte_enable,
   output logic [31:0] mem_rdata,
   output logic        mem_resp,
   output logic        bus_req_valid,
   input  logic        bus_req_ready,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wmask,
   input  logic        bus_rsp_valid,
   input  logic [31:0] bus_rdata,
   output logic        err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   // The timeout limit must fit in the 8-bit counter and be non-zero.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("mem_bridge: TIMEOUT_CYCLES must be in 1..255");
   end

   logic [1:0]  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        we_q, we_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        timeout_hit;

`ifdef MEM_BRIDGE_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   logic [7:0] cnt_q, cnt_d;

   // A timeout fires in the WAIT cycle whose increment would reach the limit.
   // A response in that same cycle takes priority in the FSM below.
   assign timeout_hit = (state_q == ST_WAIT) && ((cnt_q + 8'd1) == TIMEOUT_LIMIT);

   // WAIT cycle counter: cleared on the REQ->WAIT handshake, counts idle WAIT cycles.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == ST_REQ && bus_req_ready) begin
         cnt_d = '0;
      end else if (state_q == ST_WAIT && !bus_rsp_valid) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Timeout counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state, capture, read-data and sticky-error logic.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      err_d   = err_q;

      case (state_q)
         ST_IDLE: begin
            if (mem_read ^ mem_write) begin
               addr_d  = {mem_address[31:2], 2'b00};
               wdata_d = mem_wdata;
               be_d    = mem_byte_enable;
               we_d    = mem_write;
               state_d = ST_REQ;
            end else if (mem_read && mem_write) begin
               err_d = 1'b1;
            end
         end
         ST_REQ: begin
            if (bus_req_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus_rsp_valid) begin
               if (!we_q) begin
                  rdata_d = bus_rdata;
               end
               state_d = ST_RESP;
            end else if (timeout_hit) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A response can only be consumed in WAIT; anywhere else it is a protocol error.
      if (bus_rsp_valid && state_q != ST_WAIT) begin
         err_d = 1'b1;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign mem_rdata     = rdata_q;
   assign mem_resp      = (state_q == ST_RESP);
   assign bus_req_valid = (state_q == ST_REQ);
   assign bus_we        = we_q;
   assign bus_addr      = addr_q;
   assign bus_wdata     = wdata_q;
   assign bus_wmask     = we_q ? be_q : 4'b0000;
   assign err           = err_q;

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: self-checking bench for mem_bridge.
// The bench uses a vector table and hand-written corner sequences. It also
// drives random transactions checked against a behavioural model. Build with
// MEM_BRIDGE_TIMEOUT_EN to exercise the timeout with TIMEOUT_CYCLES=4.
module tb_mem_bridge;

`ifdef MEM_BRIDGE_TIMEOUT_EN
   localparam int unsigned TB_TIMEOUT = 4;
`else
   localparam int unsigned TB_TIMEOUT = 255;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [31:0] mem_address, mem_wdata;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_rdata;
   logic        mem_resp;
   logic        bus_req_valid, bus_req_ready, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_wmask;
   logic        bus_rsp_valid;
   logic [31:0] bus_rdata;
   logic        err;

   always #5 clk = ~clk;

   mem_bridge #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
      .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_wmask(bus_wmask), .bus_rsp_valid(bus_rsp_valid),
      .bus_rdata(bus_rdata), .err(err)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int hs_cnt   = 0;
   int resp_cnt = 0;

   // Scoreboard state: last returned read data and the sticky error flag.
   logic [31:0] model_rdata;
   logic        err_m;

   // Count bus handshakes and completion pulses mid-cycle.
   always @(negedge clk) begin
      if (bus_req_valid && bus_req_ready) hs_cnt++;
      if (mem_resp) resp_cnt++;
   end

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          rdy;
      int          rsp;
      logic [31:0] rdata;
      logic [31:0] exp_addr;
      logic [3:0]  exp_wmask;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[5];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One CPU transaction. Ready arrives after rdy_dly REQ cycles and the
   // response after rsp_dly WAIT cycles. With hold=1 the request stays
   // asserted and the task returns in the mem_resp cycle.
   task automatic do_txn(input string tag, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int rdy_dly, input int rsp_dly,
                         input logic [31:0] rdata, input logic [31:0] exp_addr,
                         input logic [3:0] exp_wmask, input logic [31:0] exp_rdata,
                         input logic exp_err, input bit hold);
      mem_read = !wr; mem_write = wr;
      mem_address = addr; mem_wdata = wdata; mem_byte_enable = be;
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = $urandom;
      step();
      // The CPU-side fields may wander once captured; the bus must not follow.
      mem_address = $urandom; mem_wdata = $urandom; mem_byte_enable = 4'($urandom);
      for (int k = 0; k <= rdy_dly; k++) begin
         bus_req_ready = (k == rdy_dly);
         chk({tag, ".req_valid"}, 32'(bus_req_valid), 32'd1);
         chk({tag, ".bus_addr"}, bus_addr, exp_addr);
         chk({tag, ".bus_we"}, 32'(bus_we), 32'(wr));
         chk({tag, ".bus_wdata"}, bus_wdata, wdata);
         chk({tag, ".bus_wmask"}, 32'(bus_wmask), 32'(exp_wmask));
         chk({tag, ".resp_early"}, 32'(mem_resp), 32'd0);
         step();
      end
      bus_req_ready = 1'b0;
      for (int k = 0; k <= rsp_dly; k++) begin
         bus_rsp_valid = (k == rsp_dly);
         if (k == rsp_dly) bus_rdata = rdata;
         chk({tag, ".wait_valid"}, 32'(bus_req_valid), 32'd0);
         chk({tag, ".wait_resp"}, 32'(mem_resp), 32'd0);
         step();
      end
      bus_rsp_valid = 1'b0; bus_rdata = $urandom;
      chk({tag, ".resp"}, 32'(mem_resp), 32'd1);
      chk({tag, ".rdata"}, mem_rdata, exp_rdata);
      chk({tag, ".err"}, 32'(err), 32'(exp_err));
      chk({tag, ".resp_valid"}, 32'(bus_req_valid), 32'd0);
      if (!hold) begin
         mem_read = 1'b0; mem_write = 1'b0;
         step();
         chk({tag, ".resp_once"}, 32'(mem_resp), 32'd0);
      end
   endtask

   initial begin
      int h0, r0;
      logic        wr;
      logic [31:0] a, wd, rd;
      logic [3:0]  be;

      vecs[0] = '{1'b0, 32'h0000_1006, 32'h0, 4'b0100, 0, 0, 32'hDEAD_BEEF,
                  32'h0000_1004, 4'b0000, 32'hDEAD_BEEF};
      vecs[1] = '{1'b1, 32'h0000_0020, 32'h0000_AB00, 4'b0010, 4, 0, 32'h7777_7777,
                  32'h0000_0020, 4'b0010, 32'hDEAD_BEEF};
      vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'h0, 4'b1111, 1, 2, 32'h1234_5678,
                  32'hFFFF_FFFC, 4'b0000, 32'h1234_5678};
      vecs[3] = '{1'b1, 32'h0000_0003, 32'h5500_0000, 4'b1000, 0, 3, 32'hAAAA_AAAA,
                  32'h0000_0000, 4'b1000, 32'h1234_5678};
      vecs[4] = '{1'b0, 32'h8000_0001, 32'h0, 4'b0011, 2, 1, 32'h0000_0000,
                  32'h8000_0000, 4'b0000, 32'h0000_0000};

      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
      mem_address = '0; mem_wdata = '0; mem_byte_enable = '0;
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = '0;
      step(); step();
      chk("rst.resp", 32'(mem_resp), 32'd0);
      chk("rst.req_valid", 32'(bus_req_valid), 32'd0);
      chk("rst.rdata", mem_rdata, 32'd0);
      chk("rst.err", 32'(err), 32'd0);
      chk("rst.bus_addr", bus_addr, 32'd0);
      chk("rst.bus_wdata", bus_wdata, 32'd0);
      chk("rst.bus_wmask", 32'(bus_wmask), 32'd0);
      chk("rst.bus_we", 32'(bus_we), 32'd0);
      rst = 1'b0;
      step();

      // Directed vector table.
      foreach (vecs[i]) begin
         h0 = hs_cnt; r0 = resp_cnt;
         do_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                vecs[i].be, vecs[i].rdy, vecs[i].rsp, vecs[i].rdata, vecs[i].exp_addr,
                vecs[i].exp_wmask, vecs[i].exp_rdata, 1'b0, 1'b0);
         chk($sformatf("vec%0d.handshakes", i), 32'(hs_cnt - h0), 32'd1);
         chk($sformatf("vec%0d.resps", i), 32'(resp_cnt - r0), 32'd1);
      end

      // Read and write together in IDLE: nothing issued, err latches until reset.
      h0 = hs_cnt;
      mem_read = 1'b1; mem_write = 1'b1; mem_address = 32'h0000_0500;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("both.req_valid", 32'(bus_req_valid), 32'd0);
         chk("both.err", 32'(err), 32'd1);
      end
      mem_read = 1'b0; mem_write = 1'b0;
      step(); step();
      chk("both.err_sticky", 32'(err), 32'd1);
      chk("both.handshakes", 32'(hs_cnt - h0), 32'd0);
      rst = 1'b1; step(); rst = 1'b0;
      chk("both.err_cleared", 32'(err), 32'd0);

      // Reset in WAIT abandons the access; the late response is a stray.
      mem_read = 1'b1; mem_address = 32'h0000_0040;
      step();
      bus_req_ready = 1'b1; step(); bus_req_ready = 1'b0;
      chk("rstwait.in_wait", 32'(bus_req_valid), 32'd0);
      rst = 1'b1; mem_read = 1'b0; step(); rst = 1'b0;
      r0 = resp_cnt;
      bus_rsp_valid = 1'b1; bus_rdata = 32'hBAD0_BAD0; step(); bus_rsp_valid = 1'b0;
      step(); step();
      chk("rstwait.no_resp", 32'(resp_cnt - r0), 32'd0);
      chk("rstwait.err", 32'(err), 32'd1);
      chk("rstwait.rdata", mem_rdata, 32'd0);
      do_txn("rstwait.next", 1'b0, 32'h0000_0044, 32'h0, 4'hF, 0, 0, 32'h0BAD_F00D,
             32'h0000_0044, 4'h0, 32'h0BAD_F00D, 1'b1, 1'b0);

      // Fetch then load, with mem_read held through the first mem_resp cycle.
      h0 = hs_cnt; r0 = resp_cnt;
      do_txn("fetch", 1'b0, 32'h0000_0100, 32'h0, 4'hF, 0, 0, 32'h1111_0000,
             32'h0000_0100, 4'h0, 32'h1111_0000, 1'b1, 1'b1);
      step();
      do_txn("load", 1'b0, 32'h0000_200A, 32'h0, 4'b1100, 1, 1, 32'h2222_0000,
             32'h0000_2008, 4'h0, 32'h2222_0000, 1'b1, 1'b0);
      step(); step();
      chk("b2b.handshakes", 32'(hs_cnt - h0), 32'd2);
      chk("b2b.resps", 32'(resp_cnt - r0), 32'd2);
      chk("b2b.idle", 32'(bus_req_valid), 32'd0);

`ifdef MEM_BRIDGE_TIMEOUT_EN
      rst = 1'b1; step(); rst = 1'b0;
      do_txn("to.pre", 1'b0, 32'h0000_0300, 32'h0, 4'hF, 0, 0, 32'h5A5A_A5A5,
             32'h0000_0300, 4'h0, 32'h5A5A_A5A5, 1'b0, 1'b0);
      mem_read = 1'b1; mem_address = 32'h0000_0304;
      step();
      bus_req_ready = 1'b1; step(); bus_req_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("to.waiting", 32'(mem_resp), 32'd0);
         step();
      end
      chk("to.resp", 32'(mem_resp), 32'd1);
      chk("to.rdata", mem_rdata, 32'd0);
      chk("to.err", 32'(err), 32'd1);
      mem_read = 1'b0; step();
      rst = 1'b1; step(); rst = 1'b0;
      do_txn("to.edge", 1'b0, 32'h0000_0308, 32'h0, 4'hF, 0, 3, 32'hCAFE_F00D,
             32'h0000_0308, 4'h0, 32'hCAFE_F00D, 1'b0, 1'b0);
`else
      mem_read = 1'b1; mem_address = 32'h0000_0600;
      step();
      bus_req_ready = 1'b1; step(); bus_req_ready = 1'b0;
      r0 = resp_cnt;
      for (int k = 0; k < 300; k++) step();
      chk("notimeout.no_resp", 32'(resp_cnt - r0), 32'd0);
      bus_rsp_valid = 1'b1; bus_rdata = 32'h600D_CAFE; step(); bus_rsp_valid = 1'b0;
      chk("notimeout.resp", 32'(mem_resp), 32'd1);
      chk("notimeout.rdata", mem_rdata, 32'h600D_CAFE);
      mem_read = 1'b0; step();
`endif

      // Random traffic against the behavioural model.
      rst = 1'b1; step(); rst = 1'b0;
      model_rdata = '0; err_m = 1'b0;
      h0 = hs_cnt; r0 = resp_cnt;
      for (int n = 0; n < 40; n++) begin
         wr = 1'($urandom_range(0, 1));
         a = $urandom; wd = $urandom; rd = $urandom; be = 4'($urandom);
         if (!wr) model_rdata = rd;
         do_txn("rnd", wr, a, wd, be, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                rd, a & 32'hFFFF_FFFC, wr ? be : 4'h0, model_rdata, err_m, 1'b0);
         if ($urandom_range(0, 7) == 0) begin
            bus_rsp_valid = 1'b1; step(); bus_rsp_valid = 1'b0;
            err_m = 1'b1;
            chk("rnd.stray_err", 32'(err), 32'd1);
         end
      end
      chk("rnd.handshakes", 32'(hs_cnt - h0), 32'd40);
      chk("rnd.resps", 32'(resp_cnt - r0), 32'd40);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
